// File: rtl/fpu_result_stage.sv
// rtl/fpu_result_stage.sv - FPU result FIFO with push-time NZCV flag capture and sticky exception bits
// Entries hold the normalised result, its flags and the producing op; outputs come only from registered state.
module fpu_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_float_type,
  input  logic        in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic        out_op,
  input  logic        sticky_clr,
  output logic [1:0]  sticky
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   res_mem_q [DEPTH];
  logic [3:0]    flg_mem_q [DEPTH];
  logic          op_mem_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    sticky_q, sticky_d;

  logic          push, pop;
  logic          sgn, exp_zero, exp_ones, mant_nz;
  logic [31:0]   norm_result;
  logic [3:0]    push_flags;

  // Field extraction; half results drop the upper half-word entirely.
  always_comb begin
    if (in_float_type) begin
      sgn         = in_result[31];
      exp_zero    = (in_result[30:23] == 8'h00);
      exp_ones    = &in_result[30:23];
      mant_nz     = |in_result[22:0];
      norm_result = in_result;
    end else begin
      sgn         = in_result[15];
      exp_zero    = (in_result[14:10] == 5'h00);
      exp_ones    = &in_result[14:10];
      mant_nz     = |in_result[9:0];
      norm_result = {16'h0000, in_result[15:0]};
    end
    push_flags = {sgn, exp_zero & ~mant_nz, exp_ones, exp_ones & mant_nz};
  end

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q != FULL_CNT);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A flagged push in the same cycle as a clear keeps its bits.
    sticky_d = sticky_clr ? 2'b00 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | push_flags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= 32'h0;
        flg_mem_q[i] <= 4'h0;
        op_mem_q[i]  <= 1'b0;
      end
    end else if (push) begin
      res_mem_q[wr_ptr_q] <= norm_result;
      flg_mem_q[wr_ptr_q] <= push_flags;
      op_mem_q[wr_ptr_q]  <= in_op;
    end
  end

  // Empty FIFO presents zeros so the outputs are clean straight out of reset.
  assign out_result = out_valid ? res_mem_q[rd_ptr_q] : 32'h0;
  assign out_flags  = out_valid ? flg_mem_q[rd_ptr_q] : 4'h0;
  assign out_op     = out_valid ? op_mem_q[rd_ptr_q]  : 1'b0;
  assign sticky     = sticky_q;

endmodule

// File: doc/fpu_result_stage.md
FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of result FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have input in_valid, 1 bit, FPU result offered this cycle.
REQ-005 The block SHALL have output in_ready, 1 bit, stage can accept a result this cycle.
REQ-006 The block SHALL have input in_result, 32 bits, raw FPU Result word.
REQ-007 The block SHALL have input in_float_type, 1 bit, 0 = half (result in bits [15:0]), 1 = single.
REQ-008 The block SHALL have input in_op, 1 bit, FPUControl of the producing operation (0 add, 1 mul).
REQ-009 The block SHALL have output out_valid, 1 bit, head entry available.
REQ-010 The block SHALL have input out_ready, 1 bit, consumer takes the head entry this cycle.
REQ-011 The block SHALL have output out_result, 32 bits, head result; half results zero-extended to 32 bits.
REQ-012 The block SHALL have output out_flags, 4 bits, {N,Z,C,V} of head entry (ALUFlags ordering: [3]=N, [2]=Z, [1]=C, [0]=V).
REQ-013 The block SHALL have output out_op, 1 bit, in_op carried with the head entry.
REQ-014 The block SHALL have input sticky_clr, 1 bit, synchronous clear of sticky flags.
REQ-015 The block SHALL have output sticky, 2 bits, {overflow_seen, nan_seen} accumulated since reset/clear.

Function
REQ-016 A push SHALL occur on a rising edge where in_valid and in_ready are both 1; a pop SHALL occur where out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_result, out_flags and out_op SHALL come from the head entry, with no combinational path from in_* to out_*.
REQ-019 Latency: a result pushed at edge k SHALL be visible at the head no earlier than after edge k; into an empty FIFO it SHALL be visible exactly after edge k.
REQ-020 Flags SHALL be computed at push time and stored with the entry. Fields: single uses sign = bit 31, exp = [30:23], mant = [22:0]; half uses sign = bit 15, exp = [14:10], mant = [9:0].
REQ-021 Flag values: N = sign; Z = (exp == 0 and mant == 0); C = (exp all ones); V = (exp all ones and mant != 0).
REQ-022 For half, bits [31:16] of in_result SHALL be ignored and stored as zero.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, with both pointers advanced.
REQ-024 Push when full SHALL be impossible because in_ready = 0; a pop when empty SHALL be ignored and no state change.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be log2(DEPTH)+1 bits.
REQ-026 On every push, sticky[1] SHALL set if C = 1 and sticky[0] SHALL set if V = 1. Sticky bits hold until sticky_clr or reset.
REQ-027 sticky_clr together with a flagged push in the same cycle SHALL leave that push's flags set, because set wins over clear.
REQ-028 Entries SHALL be popped in push order; data at the head SHALL stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 Reset SHALL immediately, without waiting for clk, force count = 0, pointers = 0, sticky = 2'b00, out_valid = 0, in_ready = 1, out_result = 0, out_flags = 0, out_op = 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; the first push after release SHALL appear at the head as if the FIFO were new.

Verification
REQ-031 Single push to empty: in_result = 32'h41100000, in_float_type = 1, in_op = 1 -> next cycle out_valid = 1, out_result = 32'h41100000, out_flags = 4'b0000, out_op = 1.
REQ-032 Half result: in_result = 32'hABCD7C01, in_float_type = 0 -> out_result = 32'h00007C01, out_flags = 4'b0011, sticky = 2'b11; then sticky_clr pulse -> sticky = 2'b00.
REQ-033 Backpressure with DEPTH = 2 and out_ready = 0: push 32'h80000000 then 32'h7F800000 -> in_ready = 0 after second push; head = 32'h80000000 with flags 4'b1100; third offer not accepted.
REQ-034 Simultaneous push/pop with count = 1 for 10 cycles on an incrementing data stream -> count stays 1 and output order matches input order across pointer wrap.
REQ-035 Asynchronous reset asserted between clock edges while count = 2 -> out_valid = 0 and in_ready = 1 before the next edge; the next push of 32'h3F800000 is the head with flags 4'b0000.
